mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between two requesters: the multicycle control unit/datapath (CPU port) and a DMA/program-loader port.
- Sits between the memory model and both requesters. Owns mem_en, mem_we and mem_byte.
- CPU has fixed priority. A starvation counter guarantees DMA progress.
- Fixed-latency memory is sequenced through an IDLE/ACCESS/WAIT/RESP state machine.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the shared fixed-latency memory port
// CPU has fixed priority; a saturating starvation counter forces a DMA grant after MAX_WAIT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_byte,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int LAT_W = (MEM_LAT  < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] starve_cnt;
  logic             xfer_we;
  logic             starved;
  logic             grant_dma;
  logic             grant_cpu;

  assign starved   = (starve_cnt >= CNT_W'(MAX_WAIT));
  assign grant_dma = (state == IDLE) && dma_req && (starved || !cpu_req);
  assign grant_cpu = (state == IDLE) && cpu_req && !grant_dma;
  assign cpu_stall = cpu_req & ~cpu_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      xfer_we   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_byte  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_cpu || grant_dma) begin
            owner     <= grant_dma;
            xfer_we   <= grant_dma ? dma_we    : cpu_we;
            mem_we    <= grant_dma ? dma_we    : cpu_we;
            mem_byte  <= grant_dma ? dma_byte  : cpu_byte;
            mem_addr  <= grant_dma ? dma_addr  : cpu_addr;
            mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          lat_cnt <= LAT_W'(MEM_LAT);
          state   <= WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          // Last wait cycle: read data is valid now, ack goes out next cycle.
          if (lat_cnt == LAT_W'(1)) begin
            if (!xfer_we) rdata <= mem_rdata;
            cpu_ack <= ~owner;
            dma_ack <= owner;
            state   <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !dma_req || grant_dma) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table plus corner-case sequences for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_byte;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_stall;
  logic        dma_req, dma_we, dma_byte;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_ack;
  logic [31:0] rdata;
  logic        mem_en, mem_we, mem_byte;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, owner;

  int n_applied = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_byte(dma_byte), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  typedef struct {
    logic        creq, cwe, cbyte;
    logic [31:0] caddr, cwd;
    logic        dreq, dwe, dbyte;
    logic [31:0] daddr, dwd, mrd;
    logic        en, we, mbyte;
    logic [31:0] maddr, mwd;
    logic        cack, dack;
    logic [31:0] rd;
    logic        bsy, own, stall;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic creq, cwe, cbyte, input logic [31:0] caddr, cwd,
                     input logic dreq, dwe, dbyte, input logic [31:0] daddr, dwd, mrd,
                     input logic en, we, mbyte, input logic [31:0] maddr, mwd,
                     input logic cack, dack, input logic [31:0] rd,
                     input logic bsy, own, stall);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.cbyte = cbyte; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.dbyte = dbyte; v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
    v.en = en; v.we = we; v.mbyte = mbyte; v.maddr = maddr; v.mwd = mwd;
    v.cack = cack; v.dack = dack; v.rd = rd; v.bsy = bsy; v.own = own; v.stall = stall;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_byte = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_byte = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
  endtask

  int en_cnt, ack_cnt;

  initial begin
    reset = 1'b1;
    idle_inputs();

    // reset state
    add(0,0,0,0,0,       0,0,0,0,0,       0,            0,0,0,0,0,       0,0,0,            0,0,0);
    // CPU read of 0x10, data valid two cycles after mem_en
    add(1,0,0,'h10,0,    0,0,0,0,0,       0,            0,0,0,0,0,       0,0,0,            0,0,1);
    add(1,0,0,'h10,0,    0,0,0,0,0,       0,            1,0,0,'h10,0,    0,0,0,            1,0,1);
    add(1,0,0,'h10,0,    0,0,0,0,0,       'h11111111,   0,0,0,0,0,       0,0,0,            1,0,1);
    add(1,0,0,'h10,0,    0,0,0,0,0,       'hDEADBEEF,   0,0,0,0,0,       0,0,0,            1,0,1);
    add(1,0,0,'h10,0,    0,0,0,0,0,       'h22222222,   0,0,0,0,0,       1,0,'hDEADBEEF,   1,0,0);
    add(0,0,0,0,0,       0,0,0,0,0,       0,            0,0,0,0,0,       0,0,'hDEADBEEF,   0,0,0);
    // simultaneous CPU read 0x20 and DMA write 0x30/0x55
    add(1,0,0,'h20,0,    1,1,0,'h30,'h55, 0,            0,0,0,0,0,       0,0,'hDEADBEEF,   0,0,1);
    add(1,0,0,'h20,0,    1,1,0,'h30,'h55, 0,            1,0,0,'h20,0,    0,0,'hDEADBEEF,   1,0,1);
    add(1,0,0,'h20,0,    1,1,0,'h30,'h55, 'h33333333,   0,0,0,0,0,       0,0,'hDEADBEEF,   1,0,1);
    add(1,0,0,'h20,0,    1,1,0,'h30,'h55, 'hCAFEF00D,   0,0,0,0,0,       0,0,'hDEADBEEF,   1,0,1);
    add(1,0,0,'h20,0,    1,1,0,'h30,'h55, 'h44444444,   0,0,0,0,0,       1,0,'hCAFEF00D,   1,0,0);
    add(0,0,0,0,0,       1,1,0,'h30,'h55, 0,            0,0,0,0,0,       0,0,'hCAFEF00D,   0,0,0);
    add(0,0,0,0,0,       1,1,0,'h30,'h55, 0,            1,1,0,'h30,'h55, 0,0,'hCAFEF00D,   1,1,0);
    add(0,0,0,0,0,       1,1,0,'h30,'h55, 'h55555555,   0,0,0,0,0,       0,0,'hCAFEF00D,   1,1,0);
    add(0,0,0,0,0,       1,1,0,'h30,'h55, 'h66666666,   0,0,0,0,0,       0,0,'hCAFEF00D,   1,1,0);
    add(0,0,0,0,0,       1,1,0,'h30,'h55, 0,            0,0,0,0,0,       0,1,'hCAFEF00D,   1,1,0);
    add(0,0,0,0,0,       0,0,0,0,0,       0,            0,0,0,0,0,       0,0,'hCAFEF00D,   0,1,0);
    // DMA byte write to 0x3
    add(0,0,0,0,0,       1,1,1,'h3,'hA5,  0,            0,0,0,0,0,       0,0,'hCAFEF00D,   0,1,0);
    add(0,0,0,0,0,       1,1,1,'h3,'hA5,  0,            1,1,1,'h3,'hA5,  0,0,'hCAFEF00D,   1,1,0);
    add(0,0,0,0,0,       1,1,1,'h3,'hA5,  'h77777777,   0,0,0,0,0,       0,0,'hCAFEF00D,   1,1,0);
    add(0,0,0,0,0,       1,1,1,'h3,'hA5,  'h88888888,   0,0,0,0,0,       0,0,'hCAFEF00D,   1,1,0);
    add(0,0,0,0,0,       1,1,1,'h3,'hA5,  0,            0,0,0,0,0,       0,1,'hCAFEF00D,   1,1,0);
    add(0,0,0,0,0,       0,0,0,0,0,       0,            0,0,0,0,0,       0,0,'hCAFEF00D,   0,1,0);
    add(0,0,0,0,0,       0,0,0,0,0,       0,            0,0,0,0,0,       0,0,'hCAFEF00D,   0,1,0);

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      next_cycle();
      cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_byte = tbl[i].cbyte;
      cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
      dma_req = tbl[i].dreq; dma_we = tbl[i].dwe; dma_byte = tbl[i].dbyte;
      dma_addr = tbl[i].daddr; dma_wdata = tbl[i].dwd; mem_rdata = tbl[i].mrd;
      @(negedge clock);
      chk($sformatf("v%0d mem_en", i),    32'(mem_en),    32'(tbl[i].en));
      chk($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(tbl[i].we));
      chk($sformatf("v%0d cpu_ack", i),   32'(cpu_ack),   32'(tbl[i].cack));
      chk($sformatf("v%0d dma_ack", i),   32'(dma_ack),   32'(tbl[i].dack));
      chk($sformatf("v%0d rdata", i),     rdata,          tbl[i].rd);
      chk($sformatf("v%0d busy", i),      32'(busy),      32'(tbl[i].bsy));
      chk($sformatf("v%0d owner", i),     32'(owner),     32'(tbl[i].own));
      chk($sformatf("v%0d cpu_stall", i), 32'(cpu_stall), 32'(tbl[i].stall));
      if (tbl[i].en) begin
        chk($sformatf("v%0d mem_addr", i),  mem_addr,       tbl[i].maddr);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata,      tbl[i].mwd);
        chk($sformatf("v%0d mem_byte", i),  32'(mem_byte),  32'(tbl[i].mbyte));
      end
    end

    // starvation: CPU keeps requesting, DMA must win the second grant
    next_cycle();
    idle_inputs();
    cpu_req = 1; cpu_addr = 'h40; dma_req = 1; dma_addr = 'h50;
    @(negedge clock); chk("starve s0 busy", 32'(busy), 0);
    next_cycle(); @(negedge clock);
    chk("starve s1 mem_en", 32'(mem_en), 1);
    chk("starve s1 owner", 32'(owner), 0);
    chk("starve s1 mem_addr", mem_addr, 'h40);
    repeat (2) next_cycle();
    next_cycle(); @(negedge clock); chk("starve s4 cpu_ack", 32'(cpu_ack), 1);
    next_cycle(); @(negedge clock);
    chk("starve s5 busy", 32'(busy), 0);
    chk("starve s5 cnt", 32'(dut.starve_cnt), 4);
    next_cycle(); @(negedge clock);
    chk("starve s6 mem_en", 32'(mem_en), 1);
    chk("starve s6 owner", 32'(owner), 1);
    chk("starve s6 mem_addr", mem_addr, 'h50);
    chk("starve s6 cnt", 32'(dut.starve_cnt), 0);
    repeat (2) next_cycle();
    next_cycle(); @(negedge clock);
    chk("starve s9 dma_ack", 32'(dma_ack), 1);
    chk("starve s9 cpu_ack", 32'(cpu_ack), 0);
    next_cycle(); cpu_req = 0; dma_req = 0;
    @(negedge clock); chk("starve s10 busy", 32'(busy), 0);

    // reset in the second WAIT cycle of a CPU read aborts it
    next_cycle();
    cpu_req = 1; cpu_addr = 'h60; mem_rdata = 'h0BADF00D;
    next_cycle(); @(negedge clock); chk("rst q1 mem_en", 32'(mem_en), 1);
    next_cycle();
    next_cycle(); reset = 1;
    next_cycle(); reset = 0;
    @(negedge clock);
    chk("rst q4 busy", 32'(busy), 0);
    chk("rst q4 mem_en", 32'(mem_en), 0);
    chk("rst q4 cpu_ack", 32'(cpu_ack), 0);
    chk("rst q4 dma_ack", 32'(dma_ack), 0);
    chk("rst q4 rdata", rdata, 0);
    chk("rst q4 owner", 32'(owner), 0);
    chk("rst q4 mem_addr", mem_addr, 0);
    chk("rst q4 mem_wdata", mem_wdata, 0);
    chk("rst q4 mem_byte", 32'(mem_byte), 0);
    next_cycle(); @(negedge clock);
    chk("rst q5 mem_en", 32'(mem_en), 1);
    chk("rst q5 mem_addr", mem_addr, 'h60);
    repeat (2) next_cycle();
    next_cycle(); @(negedge clock);
    chk("rst q8 cpu_ack", 32'(cpu_ack), 1);
    chk("rst q8 rdata", rdata, 'h0BADF00D);
    next_cycle(); cpu_req = 0;
    @(negedge clock); chk("rst q9 busy", 32'(busy), 0);

    // cpu_req dropped during WAIT still completes with exactly one ack
    en_cnt = 0; ack_cnt = 0;
    for (int p = 0; p < 13; p++) begin
      next_cycle();
      if (p == 0) begin cpu_req = 1; cpu_addr = 'h80; mem_rdata = 'h600DCAFE; end
      if (p == 2) cpu_req = 0;
      @(negedge clock);
      if (mem_en) en_cnt++;
      if (cpu_ack) ack_cnt++;
      if (p == 4) begin
        chk("drop p4 cpu_ack", 32'(cpu_ack), 1);
        chk("drop p4 rdata", rdata, 'h600DCAFE);
      end
    end
    chk("drop ack count", 32'(ack_cnt), 1);
    chk("drop grant count", 32'(en_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
    $finish;
  end

endmodule
